// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes and slice-wide sizing constants.
package alu_pkg;

    localparam int unsigned NREQ = 2;
    localparam int unsigned DW   = 32;

    typedef enum logic [3:0] {
        alu_add  = 4'b0000,
        alu_sub  = 4'b0001,
        alu_and  = 4'b0010,
        alu_or   = 4'b0011,
        alu_xor  = 4'b0100,
        alu_sll  = 4'b0101,
        alu_srl  = 4'b0110,
        alu_sra  = 4'b0111,
        alu_slt  = 4'b1000,
        alu_sltu = 4'b1001
    } alu_op_e;

    // Control code driven to the shared ALU when nobody is granted
    localparam logic [3:0] ALU_IDLE_CTRL = 4'b0000;

endpackage

// File: rtl/arb2_rr.sv
// Two-requester arbiter for the shared ALU.
// ALU_ARB_RR_EN defined   : round-robin, 1-bit prio pointer favours the
//                           requester that was not granted last.
// ALU_ARB_RR_EN undefined : fixed priority, requester 0 always wins.
module arb2_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
    logic prio;

    // Contention goes to prio, a lone eligible requester always wins
    always_comb begin
        grant = '0;
        if (elig == 2'b11) begin
            grant[prio] = 1'b1;
        end else begin
            grant = elig;
        end
    end

    // After a grant, favour the other requester next time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (|grant) begin
            prio <= grant[0];
        end
    end
`else
    logic unused_clk_rst;

    // Requester 0 has absolute priority
    always_comb begin
        grant[0] = elig[0];
        grant[1] = elig[1] & ~elig[0];
    end

    // No state in fixed-priority mode
    always_comb begin
        unused_clk_rst = clk & rst_n;
    end
`endif

endmodule

// File: rtl/alu_arb.sv
// Arbitrates two requesters onto one external combinational ALU and
// returns each result through a per-requester one-entry response slot.
// Arbitration policy selected by ALU_ARB_RR_EN (see arb2_rr).
module alu_arb
    import alu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][DW-1:0]   req_a,
    input  logic [NREQ-1:0][DW-1:0]   req_b,
    input  logic [NREQ-1:0][3:0]      req_op,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [NREQ-1:0][DW-1:0]   rsp_data,
    output logic [NREQ-1:0]           rsp_zero,
    output logic [DW-1:0]             alu_inA,
    output logic [DW-1:0]             alu_inB,
    output logic [3:0]                alu_ctrl,
    input  logic [DW-1:0]             alu_out,
    input  logic                      alu_zero
);

    logic [NREQ-1:0] slot_free;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;

    // A slot is free when empty or being drained this cycle; reset blocks all grants
    always_comb begin
        slot_free = ~rsp_valid | rsp_ready;
        elig      = req_valid & slot_free & {NREQ{rst_n}};
        req_ready = grant;
    end

    arb2_rr u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig),
        .grant (grant)
    );

    // Steer the granted requester's operands to the shared ALU
    always_comb begin
        alu_inA  = '0;
        alu_inB  = '0;
        alu_ctrl = ALU_IDLE_CTRL;
        if (grant[0]) begin
            alu_inA  = req_a[0];
            alu_inB  = req_b[0];
            alu_ctrl = req_op[0];
        end else if (grant[1]) begin
            alu_inA  = req_a[1];
            alu_inB  = req_b[1];
            alu_ctrl = req_op[1];
        end
    end

    // Response slots: a new accept overrides the drain of the previous result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_zero  <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_valid[i] && grant[i]) begin
                    rsp_valid[i] <= 1'b1;
                    rsp_data[i]  <= alu_out;
                    rsp_zero[i]  <= alu_zero;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: behavioural ALU on the external port,
// per-cycle reference model of slots and arbitration, directed + random tests.
module tb_alu_arb;
    import alu_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][3:0]  req_op;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_data;
    logic [1:0]       rsp_zero;
    logic [31:0]      alu_inA;
    logic [31:0]      alu_inB;
    logic [3:0]       alu_ctrl;
    logic [31:0]      alu_out;
    logic             alu_zero;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // reference model state
    logic [1:0]       m_rv;
    logic [1:0][31:0] m_rd;
    logic [1:0]       m_rz;
    logic             m_prio;

    always #5 clk = ~clk;

    alu_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .alu_inA   (alu_inA),
        .alu_inB   (alu_inB),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero)
    );

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        case (op)
            alu_add:  return a + b;
            alu_sub:  return a - b;
            alu_and:  return a & b;
            alu_or:   return a | b;
            alu_xor:  return a ^ b;
            alu_sll:  return a << b[4:0];
            alu_srl:  return a >> b[4:0];
            alu_sra:  return $unsigned($signed(a) >>> b[4:0]);
            alu_slt:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            alu_sltu: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    // external shared ALU
    assign alu_out  = ref_alu(alu_inA, alu_inB, alu_ctrl);
    assign alu_zero = (alu_out == 32'd0);

    // who should be granted this cycle, from the model state and current inputs
    function automatic logic [1:0] exp_grant();
        logic [1:0] el;
        el = req_valid & (~m_rv | rsp_ready);
        if (!rst_n) return 2'b00;
`ifdef ALU_ARB_RR_EN
        if (el == 2'b11) return m_prio ? 2'b10 : 2'b01;
`else
        if (el == 2'b11) return 2'b01;
`endif
        return el;
    endfunction

    task automatic model_reset();
        m_rv   = 2'b00;
        m_rd   = '0;
        m_rz   = 2'b00;
        m_prio = 1'b0;
    endtask

    // advance one clock, updating the model with the inputs seen at the edge
    task automatic tick();
        logic [1:0] g;
        g = exp_grant();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                m_rv[i] = 1'b1;
                m_rd[i] = ref_alu(req_a[i], req_b[i], req_op[i]);
                m_rz[i] = (m_rd[i] == 32'd0);
            end else if (m_rv[i] && rsp_ready[i]) begin
                m_rv[i] = 1'b0;
            end
        end
        if (|g) m_prio = g[0];
        #1;
    endtask

    task automatic drain();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        req_op    = {4'b0000, 4'b0001};
        model_reset();
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid);
        end
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        n_checks++;
        if (rsp_data !== 64'd0 || rsp_zero !== 2'b00) begin
            n_fail++; $display("FAIL reset_rsp_data: got %h/%b expected 0/00", rsp_data, rsp_zero);
        end
        n_checks++;
        if (alu_ctrl !== 4'b0000 || alu_inA !== 32'd0 || alu_inB !== 32'd0) begin
            n_fail++; $display("FAIL reset_alu_idle: got %h %h %h expected 0 0 0", alu_inA, alu_inB, alu_ctrl);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        drain();
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        req_a[0]  = 32'd5;
        req_b[0]  = 32'd3;
        req_op[0] = alu_sub;
        @(negedge clk);
        n_checks++;
        if (alu_ctrl !== 4'b0001 || req_ready !== 2'b01) begin
            n_fail++; $display("FAIL single_grant: got ctrl=%b ready=%b expected 0001 01", alu_ctrl, req_ready);
        end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd2 || rsp_zero[0] !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp: got v=%b d=%h z=%b expected 1 2 0",
                               rsp_valid[0], rsp_data[0], rsp_zero[0]);
        end
        tick();
    endtask

    task automatic test_arbitration();
        logic [1:0] first;
        logic [1:0] want;
        drain();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        first = exp_grant();
        for (int k = 0; k < 8; k++) begin
            req_a  = {$urandom, $urandom};
            req_b  = {$urandom, $urandom};
            req_op = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
`ifdef ALU_ARB_RR_EN
            want = ((k % 2) == 0) ? first : ~first;
`else
            want = 2'b01;
`endif
            @(negedge clk);
            n_checks++;
            if (req_ready !== want) begin
                n_fail++; $display("FAIL arb_pattern[%0d]: got %b expected %b", k, req_ready, want);
            end
            n_checks++;
            if (rsp_valid !== m_rv) begin
                n_fail++; $display("FAIL arb_rsp_valid[%0d]: got %b expected %b", k, rsp_valid, m_rv);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        drain();
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        req_a[1]  = $urandom;
        req_b[1]  = $urandom;
        req_op[1] = alu_xor;
        @(negedge clk);
        tick();
        held      = m_rd[1];
        req_valid = 2'b11;
        rsp_ready = 2'b01;
        req_a[0]  = 32'd7;
        req_b[0]  = 32'd7;
        req_op[0] = alu_sub;
        req_a[1]  = $urandom;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL stall_ready: got %b expected 01", req_ready);
        end
        n_checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== held) begin
            n_fail++; $display("FAIL stall_hold_a: got v=%b d=%h expected 1 %h", rsp_valid[1], rsp_data[1], held);
        end
        tick();
        req_valid = 2'b10;
        @(negedge clk);
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd0 || rsp_zero[0] !== 1'b1) begin
            n_fail++; $display("FAIL stall_req0_rsp: got v=%b d=%h z=%b expected 1 0 1",
                               rsp_valid[0], rsp_data[0], rsp_zero[0]);
        end
        n_checks++;
        if (req_ready[1] !== 1'b0 || rsp_data[1] !== held) begin
            n_fail++; $display("FAIL stall_hold_b: got r=%b d=%h expected 0 %h", req_ready[1], rsp_data[1], held);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drain();
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        req_a[0]  = 32'hFFFF_FFFF;
        req_b[0]  = 32'd1;
        req_op[0] = alu_slt;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL b2b_ready: got %b expected 01", req_ready);
        end
        tick();
        req_op[0] = alu_sltu;
        @(negedge clk);
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd1 || req_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_slt: got v=%b d=%h r=%b expected 1 1 1",
                               rsp_valid[0], rsp_data[0], req_ready[0]);
        end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd0) begin
            n_fail++; $display("FAIL b2b_sltu: got v=%b d=%h expected 1 0", rsp_valid[0], rsp_data[0]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [1:0]  g;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  ec;
        for (int k = 0; k < 400; k++) begin
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                req_a[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                req_b[i]  = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
                req_op[i] = 4'($urandom_range(0, 15));
            end
            g  = exp_grant();
            ea = 32'd0; eb = 32'd0; ec = 4'b0000;
            if (g[0]) begin
                ea = req_a[0]; eb = req_b[0]; ec = req_op[0];
            end else if (g[1]) begin
                ea = req_a[1]; eb = req_b[1]; ec = req_op[1];
            end
            @(negedge clk);
            n_checks++;
            if (req_ready !== g) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", k, req_ready, g);
            end
            n_checks++;
            if (alu_inA !== ea || alu_inB !== eb || alu_ctrl !== ec) begin
                n_fail++; $display("FAIL rand_alu_mux[%0d]: got %h %h %b expected %h %h %b",
                                   k, alu_inA, alu_inB, alu_ctrl, ea, eb, ec);
            end
            n_checks++;
            if (rsp_valid !== m_rv) begin
                n_fail++; $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", k, rsp_valid, m_rv);
            end
            for (int i = 0; i < 2; i++) begin
                if (m_rv[i]) begin
                    n_checks++;
                    if (rsp_data[i] !== m_rd[i] || rsp_zero[i] !== m_rz[i]) begin
                        n_fail++; $display("FAIL rand_rsp_data[%0d][%0d]: got %h/%b expected %h/%b",
                                           k, i, rsp_data[i], rsp_zero[i], m_rd[i], m_rz[i]);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drain();
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        req_a[0]  = 32'd10;
        req_b[0]  = 32'd4;
        req_op[0] = alu_add;
        @(negedge clk);
        tick();
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL midreset_clear: got v=%b r=%b expected 00 00", rsp_valid, req_ready);
        end
`ifdef ALU_ARB_RR_EN
        n_checks++;
        if (dut.u_arb.prio !== 1'b0) begin
            n_fail++; $display("FAIL midreset_prio: got %b expected 0", dut.u_arb.prio);
        end
`endif
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 2'b00) begin
                n_fail++; $display("FAIL midreset_no_rsp[%0d]: got %b expected 00", k, rsp_valid);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports req_valid/req_ready  input/output  [1:0]  per-requester request handshake.
REQ-004 SHALL have ports req_a, req_b  input  [1:0][31:0]  operands; req_op  input  [1:0][3:0]  ALU control code.
REQ-005 SHALL have ports rsp_valid  output  [1:0], rsp_ready  input  [1:0]  per-requester response handshake.
REQ-006 SHALL have ports rsp_data  output  [1:0][31:0] and rsp_zero  output  [1:0]  registered result and Zero flag.
REQ-007 SHALL have ports alu_inA, alu_inB  output  32; alu_ctrl  output  4  driving the shared external ALU.
REQ-008 SHALL have ports alu_out  input  32 and alu_zero  input  1  from the shared ALU (combinational path).

Function
REQ-009 SHALL hold one result slot per requester i; slot i free = !rsp_valid[i] | rsp_ready[i].
REQ-010 SHALL treat requester i as eligible when req_valid[i] & slot i free.
REQ-011 SHALL grant at most one eligible requester per cycle; req_ready[i] = grant[i], asserted only with req_valid[i].
REQ-012 SHALL drive alu_inA/alu_inB/alu_ctrl from the granted requester; with no grant, drive 0/0/4'b0000.
REQ-013 SHALL, on accept (req_valid&req_ready), load alu_out/alu_zero into slot i and set rsp_valid[i] next cycle: latency exactly 1 cycle.
REQ-014 SHALL clear rsp_valid[i] on rsp_valid[i]&rsp_ready[i] unless a new accept for i occurs the same cycle, which SHALL win (back-to-back throughput 1/cycle per requester).
REQ-015 SHALL hold rsp_data/rsp_zero stable while rsp_valid[i]&!rsp_ready[i].
REQ-016 SHALL pass codes 4'b1010-4'b1111 unchanged; slot captures ALU output (0) and alu_zero as given, no error signalling.
REQ-017 SHALL keep requester-0 and requester-1 responses independent: a stalled rsp on one side never blocks the other.
REQ-018 SHALL keep a 1-bit priority pointer prio (favoured requester); in round-robin mode prio <= ~granted index after each grant, unchanged with no grant.
REQ-019 SHALL, when both eligible, grant prio; when one eligible, grant it regardless of prio.

Reset
REQ-020 SHALL, on rst_n low (async), clear rsp_valid to 2'b00, rsp_data to 0, rsp_zero to 0, prio to 0.
REQ-021 SHALL drop any in-flight accept when reset asserts mid-cycle; no response produced for it.
REQ-022 SHALL hold req_ready at 0 while rst_n is low.

Configuration
REQ-023 SHALL use macro ALU_ARB_RR_EN: defined -> round-robin per REQ-018/019; undefined -> fixed priority, requester 0 always wins, prio register absent.

Structure
REQ-024 SHALL place ALU control code constants (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001) as a typedef enum in shared package alu_pkg.
REQ-025 SHALL isolate grant logic and prio pointer in one sub-module arb2_rr; datapath muxing and slots stay in alu_arb.

Verification
REQ-026 SHALL test: single req0 a=5,b=3,op=0001 -> alu_ctrl=0001 same cycle, next cycle rsp_valid[0]=1, rsp_data[0]=2, rsp_zero[0]=0.
REQ-027 SHALL test: both valid every cycle, rsp_ready=11, RR build -> grants alternate 0,1,0,1; fixed build -> req0 every cycle, req1 starved.
REQ-028 SHALL test: req1 rsp_ready=0 with rsp pending, req1 valid -> req_ready[1]=0, rsp_data[1] held; req0 a=b=7 op=0001 still completes with rsp_zero[0]=1.
REQ-029 SHALL test: req0 a=32'hFFFFFFFF,b=1,op=1000 then op=1001 back-to-back, rsp_ready=1 -> rsp_data 1 then 0 on consecutive cycles.
REQ-030 SHALL test: rst_n low one cycle after accept before rsp taken -> rsp_valid=00, prio=0 immediately; no response after release.
